// File: rtl/irq_request_latch_pkg.sv
// Shared constants, state encoding and helpers for the interrupt request latch.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_request_latch_pkg;

    localparam int N_REQ = 8;
    localparam int VEC_W = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Idle level of the active-low request lines; sync chain and prev regs reset here
    localparam logic [N_REQ-1:0] SYNC_IDLE = 8'hFF;

    // One-hot mask selecting the request bit named by an index
    function automatic logic [N_REQ-1:0] vec_onehot(input logic [VEC_W-1:0] v);
        logic [N_REQ-1:0] oh;
        oh    = '0;
        oh[v] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/irq_request_latch_req_sync_edge.sv
// Synchronises the raw active-low request lines and flags falling edges.
// Latency: SYNC_STAGES cycles to sync; fall is combinational from sync and prev.
// Backpressure: none, free-running every cycle.
module req_sync_edge
    import irq_request_latch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_n,
    output logic [N_REQ-1:0] sync,
    output logic [N_REQ-1:0] fall
);

    logic [N_REQ-1:0] chain [SYNC_STAGES];
    logic [N_REQ-1:0] prev;

    // Shift raw requests through the synchroniser and keep last cycle's synced value.
    // Resetting to the idle level means a line held low across reset release
    // produces exactly one edge once the chain has filled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                chain[s] <= SYNC_IDLE;
            end
            prev <= SYNC_IDLE;
        end else begin
            chain[0] <= req_n;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                chain[s] <= chain[s-1];
            end
            prev <= sync;
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    // A bit was high last cycle and is low now: new active-low request
    assign fall = prev & ~sync;

endmodule

// File: rtl/irq_request_latch.sv
// Latches request edges into a pending register and hands the external encoder's winner out on valid/ready.
// Latency: synced edge -> pending next cycle -> irq_valid the cycle after; one IDLE cycle between deliveries.
// Backpressure: irq_vec is held with irq_valid high until irq_ready; pending keeps collecting meanwhile.
module irq_request_latch
    import irq_request_latch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_n,
    input  logic [N_REQ-1:0] mask,
    input  logic             enable,
    output logic [N_REQ-1:0] enc_v,
    output logic             enc_en_n,
    input  logic [VEC_W-1:0] enc_y,
    input  logic             enc_gs,
    input  logic             enc_en_out,
    output logic             irq_valid,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ready,
    output logic [N_REQ-1:0] pending,
    output logic             quiet
);

    logic [N_REQ-1:0] sync;
    logic [N_REQ-1:0] fall;
    logic [N_REQ-1:0] clr;
    logic             accept;
    logic             load;
    state_t           state_q;
    state_t           state_d;

    req_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .req_n (req_n),
        .sync  (sync),
        .fall  (fall)
    );

    // Encoder drive comes straight from registers so its y/gs settle within the cycle
    assign enc_v    = ~(pending & ~mask);
    assign enc_en_n = ~enable;

    // Only the delivered bit is cleared, and only in edge mode
    assign clr = (EDGE_MODE && accept) ? vec_onehot(irq_vec) : '0;

    // Pending register: a new edge beats the clear on the same bit so it is re-delivered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (EDGE_MODE) begin
            pending <= (pending & ~clr) | fall;
        end else begin
            pending <= ~sync;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: arbitrate in IDLE, hold until accepted in PRESENT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable && !enc_gs) state_d = ST_PRESENT;
            ST_PRESENT: if (irq_ready)         state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; valid is purely state-based so it can never be retracted
    always_comb begin
        irq_valid = (state_q == ST_PRESENT);
        accept    = irq_valid && irq_ready;
        load      = (state_q == ST_IDLE) && enable && !enc_gs;
        quiet     = (state_q == ST_IDLE) && !enc_en_out;
    end

    // Capture the winner only when leaving IDLE; later priority/mask/enable changes cannot disturb it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_vec <= '0;
        end else if (load) begin
            irq_vec <= enc_y;
        end
    end

endmodule
